// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It merges four hold/flush sources into one set of pipeline-register enables:
//   - data-memory wait
//   - multi-cycle EX operations
//   - taken branches
//   - load-use hazards
// It also issues the multi-cycle unit start pulse, flags memory timeouts and
// counts stall cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue; a multi-cycle op in EX starts the unit
// MC_BUSY | multi-cycle unit running; front end held until mc_done
module pipeline_stall_controller #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       stallctrlin_id_rs1_addr,
   input  logic [4:0]       stallctrlin_id_rs2_addr,
   input  logic             stallctrlin_id_rs1_used,
   input  logic             stallctrlin_id_rs2_used,
   input  logic [4:0]       stallctrlin_ex_rd_addr,
   input  logic             stallctrlin_ex_is_load,
   input  logic             stallctrlin_ex_branch_taken,
   input  logic             stallctrlin_ex_mc_op,
   input  logic             stallctrlin_mc_done,
   input  logic             stallctrlin_mem_req,
   input  logic             stallctrlin_mem_ready,
   output logic             stallctrlout_pc_write,
   output logic             stallctrlout_ifid_write,
   output logic             stallctrlout_idex_write,
   output logic             stallctrlout_exmem_write,
   output logic             stallctrlout_ifid_flush,
   output logic             stallctrlout_idex_flush,
   output logic             stallctrlout_exmem_flush,
   output logic             stallctrlout_memwb_flush,
   output logic             stallctrlout_mc_start,
   output logic             stallctrlout_mem_timeout,
   output logic [CNT_W-1:0] stallctrlout_stall_count
);

   typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

   localparam logic [15:0] LP_TIMEOUT = 16'(MEM_TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_mc_done_seen;
   logic             w_done_seen_nxt;
   logic [15:0]      r_wait_cnt;
   logic [15:0]      w_wait_inc;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_count;

   logic w_mem_freeze, w_mc_hold, w_load_use, w_rs1_hit, w_rs2_hit;
   logic w_pc_write, w_ifid_write, w_idex_write, w_exmem_write;
   logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush, w_mc_start;

   assign w_mem_freeze = stallctrlin_mem_req & ~stallctrlin_mem_ready;
   assign w_rs1_hit    = stallctrlin_id_rs1_used & (stallctrlin_id_rs1_addr == stallctrlin_ex_rd_addr);
   assign w_rs2_hit    = stallctrlin_id_rs2_used & (stallctrlin_id_rs2_addr == stallctrlin_ex_rd_addr);
   assign w_load_use   = stallctrlin_ex_is_load & (stallctrlin_ex_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);
   // A done pulse seen while memory was frozen releases the hold just like a live pulse.
   assign w_mc_hold    = ((r_state == RUN) & stallctrlin_ex_mc_op) |
                         ((r_state == MC_BUSY) & ~stallctrlin_mc_done & ~r_mc_done_seen);

   // Priority resolution: memory freeze, multi-cycle hold, branch, load-use.
   always_comb begin
      w_pc_write      = 1'b1;
      w_ifid_write    = 1'b1;
      w_idex_write    = 1'b1;
      w_exmem_write   = 1'b1;
      w_ifid_flush    = 1'b0;
      w_idex_flush    = 1'b0;
      w_exmem_flush   = 1'b0;
      w_memwb_flush   = 1'b0;
      w_mc_start      = 1'b0;
      w_state_nxt     = r_state;
      w_done_seen_nxt = r_mc_done_seen;
      if (w_mem_freeze) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_write  = 1'b0;
         w_exmem_write = 1'b0;
         w_memwb_flush = 1'b1;
         if ((r_state == MC_BUSY) && stallctrlin_mc_done)
            w_done_seen_nxt = 1'b1;
      end else if (w_mc_hold) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_write  = 1'b0;
         w_exmem_flush = 1'b1;
         // Start only from RUN; leaving RUN on this edge prevents a second pulse.
         if (r_state == RUN) begin
            w_mc_start  = 1'b1;
            w_state_nxt = MC_BUSY;
         end
      end else begin
         if (r_state == MC_BUSY) begin
            w_state_nxt     = RUN;
            w_done_seen_nxt = 1'b0;
         end
         if (stallctrlin_ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
         end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
         end
      end
   end

   // FSM state and latched done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= RUN;
         r_mc_done_seen <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_mc_done_seen <= w_done_seen_nxt;
      end
   end

   // The wait counter saturates so a very long wait can never wrap and re-arm.
   assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

   // Consecutive memory-wait counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wait_cnt    <= 16'd0;
         r_mem_timeout <= 1'b0;
      end else if (w_mem_freeze) begin
         r_wait_cnt <= w_wait_inc;
         if (w_wait_inc >= LP_TIMEOUT)
            r_mem_timeout <= 1'b1;
      end else begin
         r_wait_cnt <= 16'd0;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_stall_count <= '0;
      else if (!w_pc_write && (r_stall_count != '1))
         r_stall_count <= r_stall_count + CNT_W'(1);
   end

   // While in reset every stage is bubbled and nothing advances.
   assign stallctrlout_pc_write    = rstn & w_pc_write;
   assign stallctrlout_ifid_write  = rstn & w_ifid_write;
   assign stallctrlout_idex_write  = rstn & w_idex_write;
   assign stallctrlout_exmem_write = rstn & w_exmem_write;
   assign stallctrlout_ifid_flush  = ~rstn | w_ifid_flush;
   assign stallctrlout_idex_flush  = ~rstn | w_idex_flush;
   assign stallctrlout_exmem_flush = ~rstn | w_exmem_flush;
   assign stallctrlout_memwb_flush = ~rstn | w_memwb_flush;
   assign stallctrlout_mc_start    = rstn & w_mc_start;
   assign stallctrlout_mem_timeout = r_mem_timeout;
   assign stallctrlout_stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed scenarios followed by
// randomized traffic, each cycle's expected outputs produced by a rule-level model.
module tb_pipeline_stall_controller;

   localparam int TO  = 4;
   localparam int CW  = 8;
   localparam int MAX = (1 << CW) - 1;

   typedef struct packed {
      logic       rstn;
      logic [4:0] rs1, rs2, rd;
      logic       rs1_used, rs2_used, is_load, br, mc_op, mc_done, mem_req, mem_ready;
   } stim_t;

   typedef struct packed {
      logic          pc, ifid, idex, exmem;
      logic          f_ifid, f_idex, f_exmem, f_memwb;
      logic          mc_start, timeout;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
   logic rs1_used = 0, rs2_used = 0, is_load = 0, br = 0, mc_op = 0, mc_done = 0;
   logic mem_req = 0, mem_ready = 0;
   logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f, mc_start, mem_to;
   logic [CW-1:0] stall_cnt;
   exp_t act;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn),
      .stallctrlin_id_rs1_addr(rs1_addr), .stallctrlin_id_rs2_addr(rs2_addr),
      .stallctrlin_id_rs1_used(rs1_used), .stallctrlin_id_rs2_used(rs2_used),
      .stallctrlin_ex_rd_addr(rd_addr), .stallctrlin_ex_is_load(is_load),
      .stallctrlin_ex_branch_taken(br), .stallctrlin_ex_mc_op(mc_op),
      .stallctrlin_mc_done(mc_done), .stallctrlin_mem_req(mem_req),
      .stallctrlin_mem_ready(mem_ready),
      .stallctrlout_pc_write(pc_w), .stallctrlout_ifid_write(ifid_w),
      .stallctrlout_idex_write(idex_w), .stallctrlout_exmem_write(exmem_w),
      .stallctrlout_ifid_flush(ifid_f), .stallctrlout_idex_flush(idex_f),
      .stallctrlout_exmem_flush(exmem_f), .stallctrlout_memwb_flush(memwb_f),
      .stallctrlout_mc_start(mc_start), .stallctrlout_mem_timeout(mem_to),
      .stallctrlout_stall_count(stall_cnt)
   );

   assign act = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, memwb_f,
                 mc_start, mem_to, stall_cnt};

   // Reference model state: is a multi-cycle op outstanding, was its done pulse
   // already observed, how long memory has waited, and the running stall total.
   bit m_busy, m_seen, m_timeout;
   int m_wait, m_stalls;
   exp_t q[$];
   int tests = 0, failed = 0, cyc = 0;

   function automatic exp_t model_out(stim_t s);
      exp_t e;
      bit frozen, lu, hold;
      frozen = s.mem_req && !s.mem_ready;
      lu = s.is_load && (s.rd != 0) &&
           ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));
      hold = m_busy ? (!s.mc_done && !m_seen) : s.mc_op;
      e = '0;
      {e.pc, e.ifid, e.idex, e.exmem} = 4'b1111;
      e.timeout = m_timeout;
      e.cnt = CW'(m_stalls);
      if (!s.rstn) begin
         {e.f_ifid, e.f_idex, e.f_exmem, e.f_memwb} = 4'b1111;
         {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000;
         e.timeout = 1'b0;
         e.cnt = '0;
      end else if (frozen) begin
         {e.pc, e.ifid, e.idex, e.exmem} = 4'b0000;
         e.f_memwb = 1'b1;
      end else if (hold) begin
         {e.pc, e.ifid, e.idex} = 3'b000;
         e.f_exmem = 1'b1;
         e.mc_start = !m_busy;
      end else if (s.br) begin
         {e.f_ifid, e.f_idex} = 2'b11;
      end else if (lu) begin
         {e.pc, e.ifid} = 2'b00;
         e.f_idex = 1'b1;
      end
      return e;
   endfunction

   // Advances the model across the rising edge that follows stimulus s.
   task automatic model_edge(stim_t s, exp_t e);
      bit frozen;
      frozen = s.mem_req && !s.mem_ready;
      if (!s.rstn) begin
         m_busy = 0; m_seen = 0; m_timeout = 0; m_wait = 0; m_stalls = 0;
         return;
      end
      if (frozen) begin
         if (m_busy && s.mc_done) m_seen = 1;
         if (m_wait < 65535) m_wait++;
         if (m_wait >= TO) m_timeout = 1;
      end else begin
         m_wait = 0;
         if (!m_busy && s.mc_op) m_busy = 1;
         else if (m_busy && (s.mc_done || m_seen)) begin
            m_busy = 0;
            m_seen = 0;
         end
      end
      if (!e.pc && m_stalls < MAX) m_stalls++;
   endtask

   task automatic step(stim_t s);
      exp_t e;
      @(negedge clk);
      rstn = s.rstn; rs1_addr = s.rs1; rs2_addr = s.rs2; rd_addr = s.rd;
      rs1_used = s.rs1_used; rs2_used = s.rs2_used; is_load = s.is_load;
      br = s.br; mc_op = s.mc_op; mc_done = s.mc_done;
      mem_req = s.mem_req; mem_ready = s.mem_ready;
      e = model_out(s);
      q.push_back(e);
      model_edge(s, e);
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rstn = 1'b1;
      s.mem_ready = 1'b1;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.rstn      = ($urandom_range(0, 599) != 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.rd        = 5'($urandom_range(0, 3));
      s.rs1_used  = 1'($urandom_range(0, 1));
      s.rs2_used  = 1'($urandom_range(0, 1));
      s.is_load   = ($urandom_range(0, 9) < 4);
      s.br        = ($urandom_range(0, 4) == 0);
      s.mc_op     = ($urandom_range(0, 4) == 0);
      s.mc_done   = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      s.mem_req   = 1'($urandom_range(0, 1));
      s.mem_ready = ($urandom_range(0, 9) < 6);
      return s;
   endfunction

   // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (act !== e) begin
               failed++;
               $display("FAIL cycle %0d outputs {pc,ifid,idex,exmem,fl_ifid,fl_idex,fl_exmem,fl_memwb,start,timeout,cnt}: got %b_%b_%0d required %b_%b_%0d",
                        cyc, act[CW+9:CW+2], act[CW+1:CW], act.cnt, e[CW+9:CW+2], e[CW+1:CW], e.cnt);
            end
            cyc++;
         end
      end
   end

   initial begin
      stim_t s;
      m_busy = 0; m_seen = 0; m_timeout = 0; m_wait = 0; m_stalls = 0;
      s = idle(); s.rstn = 0;
      repeat (2) step(s);

      s = idle(); s.is_load = 1; s.rd = 5; s.rs1 = 5; s.rs1_used = 1;
      step(s);
      s.rd = 0; s.rs1 = 0;
      step(s);
      s = idle(); s.is_load = 1; s.rd = 5; s.rs2 = 5; s.rs2_used = 1; s.br = 1;
      step(s);
      s.br = 0;
      step(s);

      // Multi-cycle op: start, eight held cycles, then done.
      s = idle(); s.mc_op = 1;
      repeat (9) step(s);
      s.mc_done = 1;
      step(s);
      s = idle();
      repeat (2) step(s);

      // Done pulse lands during a three-cycle memory freeze.
      s = idle(); s.mc_op = 1;
      repeat (3) step(s);
      s.mem_req = 1; s.mem_ready = 0;
      step(s);
      s.mc_done = 1;
      step(s);
      s.mc_done = 0;
      step(s);
      s.mem_ready = 1;
      step(s);
      s = idle();
      step(s);

      // Branch held while frozen, acted on at the first unfrozen cycle.
      s = idle(); s.br = 1; s.mem_req = 1; s.mem_ready = 0;
      repeat (2) step(s);
      s.mem_ready = 1;
      step(s);

      // Timeout: six frozen cycles, then ready; flag stays until reset.
      s = idle(); s.mem_req = 1; s.mem_ready = 0;
      repeat (6) step(s);
      s.mem_ready = 1;
      repeat (3) step(s);
      s = idle(); s.rstn = 0;
      step(s);
      s = idle();
      step(s);

      // Reset asserted while the multi-cycle unit is busy.
      s = idle(); s.mc_op = 1;
      repeat (3) step(s);
      s.rstn = 0;
      repeat (2) step(s);
      s.rstn = 1;
      repeat (2) step(s);
      s = idle();
      step(s);

      repeat (2000) step(rnd());

      s = idle();
      step(s);
      @(negedge clk);
      #5;
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
